// File: rtl/count_checker_pkg.sv
// Shared types and constants for the count checker: FSM state encoding and
// the err_code values reported on a mismatch.
package count_chk_pkg;

   typedef enum logic {
      UNSYNC = 1'b0,
      LOCKED = 1'b1
   } chk_state_t;

   localparam logic [1:0] ERR_NONE  = 2'b00;
   localparam logic [1:0] ERR_COUNT = 2'b01;
   localparam logic [1:0] ERR_OVF   = 2'b10;
   localparam logic [1:0] ERR_BOTH  = 2'b11;

endpackage

// File: rtl/count_checker_if.sv
// Bundle of observed counter signals and checker status outputs. The master
// side drives the observed counter; the slave side is the checker itself.
interface count_checker_if #(
   parameter int WIDTH      = 4,
   parameter int ERR_CNT_W  = 8,
   parameter int WRAP_CNT_W = 8
) ();

   logic                  clear;
   logic                  enable;
   logic [WIDTH-1:0]      count_in;
   logic                  overflow_in;
   logic                  locked;
   logic                  mismatch;
   logic [1:0]            err_code;
   logic                  sticky_err;
   logic [ERR_CNT_W-1:0]  err_count;
   logic [WRAP_CNT_W-1:0] wrap_count;

   modport master (
      output clear, enable, count_in, overflow_in,
      input  locked, mismatch, err_code, sticky_err, err_count, wrap_count
   );

   modport slave (
      input  clear, enable, count_in, overflow_in,
      output locked, mismatch, err_code, sticky_err, err_count, wrap_count
   );

endinterface

// File: rtl/count_checker_sat_counter.sv
// Saturating up counter with synchronous clear; holds at all-ones instead of
// rolling over so statistics never appear to reset on their own.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   // Clear wins over increment; increment is ignored once the counter is full.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/count_checker.sv
// Checker for the enable-gated up counter: predicts each transition from the
// previously observed value and enable, and keeps error/wrap statistics.
module count_checker
   import count_chk_pkg::*;
#(
   parameter int WIDTH      = 4,
   parameter int ERR_CNT_W  = 8,
   parameter int WRAP_CNT_W = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   count_checker_if.slave  bus
);

   chk_state_t       state_q, state_d;
   logic [WIDTH-1:0] ref_q;
   logic             en_q;
   logic             mismatch_q, mismatch_d;
   logic [1:0]       err_code_q, err_code_d;
   logic             sticky_q, sticky_d;

   logic [WIDTH-1:0] exp_count;
   logic             exp_ovf;
   logic             cnt_bad;
   logic             ovf_bad;
   logic             check_err;
   logic             wrap_inc;

   // State and error registers; ref_q/en_q reload every edge so a single
   // fault is re-adopted and does not cascade into further errors.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= UNSYNC;
         ref_q      <= '0;
         en_q       <= 1'b0;
         mismatch_q <= 1'b0;
         err_code_q <= ERR_NONE;
         sticky_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         ref_q      <= bus.count_in;
         en_q       <= bus.enable;
         mismatch_q <= mismatch_d;
         err_code_q <= err_code_d;
         sticky_q   <= sticky_d;
      end
   end

   // Prediction, comparison and next-state; clear discards any same-cycle error.
   always_comb begin
      state_d    = state_q;
      mismatch_d = 1'b0;
      err_code_d = err_code_q;
      sticky_d   = sticky_q;
      exp_count  = en_q ? (ref_q + 1'b1) : ref_q;
      exp_ovf    = en_q && (ref_q == {WIDTH{1'b1}});
      cnt_bad    = (bus.count_in != exp_count);
      ovf_bad    = (bus.overflow_in != exp_ovf);
      check_err  = 1'b0;
      wrap_inc   = 1'b0;

      unique case (state_q)
         UNSYNC: begin
            state_d = LOCKED;
         end
         LOCKED: begin
            state_d   = LOCKED;
            check_err = cnt_bad || ovf_bad;
            wrap_inc  = bus.overflow_in;
         end
         default: begin
            state_d = UNSYNC;
         end
      endcase

      if (bus.clear) begin
         state_d    = UNSYNC;
         check_err  = 1'b0;
         wrap_inc   = 1'b0;
         mismatch_d = 1'b0;
         err_code_d = ERR_NONE;
         sticky_d   = 1'b0;
      end else if (check_err) begin
         mismatch_d = 1'b1;
         err_code_d = {ovf_bad, cnt_bad};
         sticky_d   = 1'b1;
      end
   end

   sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (bus.clear),
      .inc   (check_err),
      .count (bus.err_count)
   );

   sat_counter #(.W(WRAP_CNT_W)) u_wrap_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (bus.clear),
      .inc   (wrap_inc),
      .count (bus.wrap_count)
   );

   assign bus.locked     = (state_q == LOCKED);
   assign bus.mismatch   = mismatch_q;
   assign bus.err_code   = err_code_q;
   assign bus.sticky_err = sticky_q;

endmodule

// File: tb/tb_count_checker.sv
// Directed bench for count_checker: a default-width instance and a 2-bit
// error-counter instance driven with identical observed-counter vectors.
module tb_count_checker;
   import count_chk_pkg::*;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;
   logic any_mm;
   int   model_cnt;

   count_checker_if #(.WIDTH(4), .ERR_CNT_W(8), .WRAP_CNT_W(8)) bus_a ();
   count_checker_if #(.WIDTH(4), .ERR_CNT_W(2), .WRAP_CNT_W(8)) bus_b ();

   count_checker #(.WIDTH(4), .ERR_CNT_W(8), .WRAP_CNT_W(8)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a.slave)
   );

   count_checker #(.WIDTH(4), .ERR_CNT_W(2), .WRAP_CNT_W(8)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input logic en, input logic [3:0] cnt,
                                input logic ovf, input logic clr);
      bus_a.enable      = en;
      bus_a.count_in    = cnt;
      bus_a.overflow_in = ovf;
      bus_a.clear       = clr;
      bus_b.enable      = en;
      bus_b.count_in    = cnt;
      bus_b.overflow_in = ovf;
      bus_b.clear       = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      bus_a.enable = 1'b1; bus_a.count_in = 4'd0; bus_a.overflow_in = 1'b0; bus_a.clear = 1'b0;
      bus_b.enable = 1'b1; bus_b.count_in = 4'd0; bus_b.overflow_in = 1'b0; bus_b.clear = 1'b0;
      #12;
      checkOutput("reset_locked",   32'(bus_a.locked),     32'd0);
      checkOutput("reset_mismatch", 32'(bus_a.mismatch),   32'd0);
      checkOutput("reset_err_code", 32'(bus_a.err_code),   32'd0);
      checkOutput("reset_errcnt",   32'(bus_a.err_count),  32'd0);
      checkOutput("reset_wrapcnt",  32'(bus_a.wrap_count), 32'd0);
      rst_n = 1'b1;
      #2;

      // Healthy run: 20 correct increments, wrapping once.
      $display("[TB] healthy run");
      any_mm    = 1'b0;
      model_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b1, 4'(model_cnt), (i > 0) && (model_cnt == 0), 1'b0);
         if (i == 0) checkOutput("lock_after_first_edge", 32'(bus_a.locked), 32'd1);
         any_mm    = any_mm | bus_a.mismatch;
         model_cnt = (model_cnt + 1) % 16;
      end
      checkOutput("healthy_no_mismatch", 32'(any_mm),           32'd0);
      checkOutput("healthy_wrap_count",  32'(bus_a.wrap_count), 32'd1);
      checkOutput("healthy_sticky",      32'(bus_a.sticky_err), 32'd0);

      // Count skip 5 -> 7.
      $display("[TB] count skip");
      applyStimulus(1'b1, 4'd4, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'd5, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'd7, 1'b0, 1'b0);
      checkOutput("skip_mismatch", 32'(bus_a.mismatch),   32'd1);
      checkOutput("skip_err_code", 32'(bus_a.err_code),   32'(ERR_COUNT));
      checkOutput("skip_errcnt",   32'(bus_a.err_count),  32'd1);
      checkOutput("skip_sticky",   32'(bus_a.sticky_err), 32'd1);
      applyStimulus(1'b1, 4'd8, 1'b0, 1'b0);
      checkOutput("skip_recover_mismatch", 32'(bus_a.mismatch),  32'd0);
      checkOutput("skip_recover_errcnt",   32'(bus_a.err_count), 32'd1);
      checkOutput("skip_code_held",        32'(bus_a.err_code),  32'(ERR_COUNT));

      // Missing overflow on 15 -> 0.
      $display("[TB] missing overflow");
      for (int v = 9; v <= 15; v++) applyStimulus(1'b1, 4'(v), 1'b0, 1'b0);
      applyStimulus(1'b1, 4'd0, 1'b0, 1'b0);
      checkOutput("noovf_err_code", 32'(bus_a.err_code),   32'(ERR_OVF));
      checkOutput("noovf_errcnt",   32'(bus_a.err_count),  32'd2);
      checkOutput("noovf_wrapcnt",  32'(bus_a.wrap_count), 32'd1);

      // Spurious overflow with enable low and count held at 9.
      for (int v = 1; v <= 9; v++) applyStimulus(v != 9, 4'(v), 1'b0, 1'b0);
      checkOutput("pre_spur_mismatch", 32'(bus_a.mismatch), 32'd0);
      applyStimulus(1'b0, 4'd9, 1'b1, 1'b0);
      checkOutput("spur_mismatch", 32'(bus_a.mismatch),   32'd1);
      checkOutput("spur_err_code", 32'(bus_a.err_code),   32'(ERR_OVF));
      checkOutput("spur_errcnt",   32'(bus_a.err_count),  32'd3);
      checkOutput("spur_wrapcnt",  32'(bus_a.wrap_count), 32'd2);

      // Clear, resync at 3 with enable low, then drift 3 -> 4 with overflow.
      $display("[TB] enable-low drift");
      applyStimulus(1'b0, 4'd9, 1'b0, 1'b1);
      checkOutput("clear_errcnt", 32'(bus_a.err_count),  32'd0);
      checkOutput("clear_sticky", 32'(bus_a.sticky_err), 32'd0);
      checkOutput("clear_locked", 32'(bus_a.locked),     32'd0);
      applyStimulus(1'b0, 4'd3, 1'b0, 1'b0);
      checkOutput("resync_locked", 32'(bus_a.locked),   32'd1);
      applyStimulus(1'b0, 4'd4, 1'b1, 1'b0);
      checkOutput("drift_mismatch", 32'(bus_a.mismatch),   32'd1);
      checkOutput("drift_err_code", 32'(bus_a.err_code),   32'(ERR_BOTH));
      checkOutput("drift_errcnt",   32'(bus_a.err_count),  32'd1);
      checkOutput("drift_wrapcnt",  32'(bus_a.wrap_count), 32'd1);
      applyStimulus(1'b0, 4'd4, 1'b0, 1'b0);
      checkOutput("drift_single_pulse", 32'(bus_a.mismatch), 32'd0);

      // Back-to-back count errors with enable low.
      applyStimulus(1'b0, 4'd6, 1'b0, 1'b0);
      checkOutput("b2b_first",  32'(bus_a.mismatch), 32'd1);
      applyStimulus(1'b0, 4'd8, 1'b0, 1'b0);
      checkOutput("b2b_second", 32'(bus_a.mismatch), 32'd1);
      checkOutput("b2b_errcnt", 32'(bus_a.err_count), 32'd3);

      // Clear collides with an injected mismatch.
      $display("[TB] clear collision");
      applyStimulus(1'b0, 4'd9, 1'b0, 1'b1);
      checkOutput("coll_mismatch", 32'(bus_a.mismatch),  32'd0);
      checkOutput("coll_errcnt",   32'(bus_a.err_count), 32'd0);
      checkOutput("coll_locked",   32'(bus_a.locked),    32'd0);
      checkOutput("coll_err_code", 32'(bus_a.err_code),  32'd0);
      applyStimulus(1'b0, 4'd9, 1'b0, 1'b0);
      checkOutput("coll_relock",   32'(bus_a.locked),    32'd1);
      checkOutput("coll_relock_mm", 32'(bus_a.mismatch), 32'd0);

      // Saturation: five errors into the 2-bit error counter.
      $display("[TB] saturation");
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) applyStimulus(1'b0, (k % 2 == 0) ? 4'd5 : 4'd0, 1'b0, 1'b0);
      checkOutput("sat_b_errcnt", 32'(bus_b.err_count),  32'd3);
      checkOutput("sat_b_sticky", 32'(bus_b.sticky_err), 32'd1);
      checkOutput("sat_a_errcnt", 32'(bus_a.err_count),  32'd5);
      applyStimulus(1'b0, 4'd9, 1'b0, 1'b0);
      checkOutput("sat_b_hold",   32'(bus_b.err_count),  32'd3);

      // Asynchronous reset mid-cycle while outputs are non-zero.
      $display("[TB] async reset");
      applyStimulus(1'b0, 4'd12, 1'b1, 1'b0);
      checkOutput("pre_rst_mismatch", 32'(bus_a.mismatch), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("arst_locked",   32'(bus_a.locked),     32'd0);
      checkOutput("arst_mismatch", 32'(bus_a.mismatch),   32'd0);
      checkOutput("arst_err_code", 32'(bus_a.err_code),   32'd0);
      checkOutput("arst_sticky",   32'(bus_a.sticky_err), 32'd0);
      checkOutput("arst_errcnt",   32'(bus_a.err_count),  32'd0);
      checkOutput("arst_wrapcnt",  32'(bus_a.wrap_count), 32'd0);
      #4;
      rst_n = 1'b1;
      applyStimulus(1'b1, 4'd2, 1'b0, 1'b0);
      checkOutput("rerst_locked", 32'(bus_a.locked), 32'd1);
      applyStimulus(1'b1, 4'd3, 1'b0, 1'b0);
      checkOutput("rerst_ok", 32'(bus_a.mismatch), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/count_checker.md
# count_checker

Hardware checker that sits on the output side of the lab's 4-bit enable-gated up counter. It observes the counter's `count`/`overflow` outputs together with the `enable` that drives the counter, predicts every transition, and flags mismatches. It keeps saturating error and wrap statistics for the PYNQ-Z2 status registers and for UVM cross-checking.

## Interface
Parameters:
- `WIDTH`, default 4: width of observed count.
- `ERR_CNT_W`, default 8: width of error counter.
- `WRAP_CNT_W`, default 8: width of wrap counter.

Ports:
- `clk`, in, 1: clock; same clock as the observed counter.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `clear`, in, 1: synchronous clear of statistics and lock.
- `enable`, in, 1: the enable that drives the observed counter, tapped at the counter's input.
- `count_in`, in, WIDTH: observed counter value (registered output of the counter).
- `overflow_in`, in, 1: observed overflow pulse.
- `locked`, out, 1: checker holds a valid reference value.
- `mismatch`, out, 1: one-cycle error pulse.
- `err_code`, out, 2: cause of the last mismatch.
  - 01 = count wrong.
  - 10 = overflow wrong.
  - 11 = both.
- `sticky_err`, out, 1: set on any mismatch; cleared only by reset or `clear`.
- `err_count`, out, ERR_CNT_W: saturating count of mismatch events.
- `wrap_count`, out, WRAP_CNT_W: saturating count of observed `overflow_in` pulses while locked.

## Operation
- Internal registers:
  - `ref_q`: last observed count.
  - `en_q`: `enable` sampled at the previous edge.
- Prediction at each edge, while in LOCKED:
  - If `en_q`=1: expected count = `ref_q`+1 mod 2^WIDTH; expected overflow = (`ref_q` == all-ones).
  - If `en_q`=0: expected count = `ref_q`; expected overflow = 0.
- FSM, 2 states:
  - **UNSYNC** (reset state): at the next edge, capture `count_in` into `ref_q` and `enable` into `en_q`, do no check, then go to LOCKED.
  - **LOCKED**: at every edge, compare `count_in`/`overflow_in` against the prediction, then reload `ref_q` from `count_in` and `en_q` from `enable`. Reloading from the observed value re-adopts it, so a single fault produces one error, not a cascade.
- On mismatch:
  - `mismatch`=1 for one cycle.
  - `err_code` updated and held until the next mismatch.
  - `sticky_err`=1.
  - `err_count` incremented, saturating at all-ones.
- On `overflow_in`=1 in LOCKED, whether expected or not: `wrap_count` incremented, saturating.
- `clear`=1 at an edge has priority over all other updates:
  - `err_count`, `wrap_count`, `sticky_err`, `mismatch` and `err_code` go to 0.
  - FSM goes to UNSYNC; a mismatch detected in the same cycle is discarded.
- Width rules:
  - Prediction arithmetic is WIDTH bits with natural wrap.
  - Both counters hold at max and never roll over.

## Timing
- Reset values:
  - `locked`=0, `mismatch`=0, `err_code`=00, `sticky_err`=0, `err_count`=0, `wrap_count`=0.
  - State UNSYNC; `ref_q`=0, `en_q`=0.
- Lock latency: `locked` rises after the first edge following reset release or `clear`.
- Check latency:
  - Counter samples `enable` at edge N.
  - Checker samples the result at edge N+1.
  - `mismatch`, `err_code` and the incremented `err_count` are visible after edge N+1, i.e. 2 edges after the offending enable.
- `wrap_count` updates at the same edge as the check of the overflowing transition.
- Reset asserted mid-operation forces all outputs to reset values immediately, without waiting for a clock edge.
- After `rst_n` releases, there is one UNSYNC cycle before checking resumes.
- Back-to-back mismatches produce back-to-back `mismatch` pulses, with no dead cycle.

## Structure
- Package `count_chk_pkg`:
  - `typedef enum logic {UNSYNC, LOCKED} chk_state_t`.
  - `err_code` localparams `ERR_NONE`, `ERR_COUNT`, `ERR_OVF`, `ERR_BOTH`.
- Sub-module `sat_counter`: parameterised width, `inc`, synchronous `clr`, async `rst_n`, saturating. It is instantiated twice, once for errors and once for wraps.
- Top level holds the FSM, prediction logic and error registers.

## Test plan
- **Healthy run:** reset release, `enable`=1 for 20 cycles with a correct counter model.
  - `locked`=1 after the first edge.
  - `mismatch` never asserted.
  - `wrap_count`=1 after the 15→0 wrap.
- **Count skip:** model jumps 5→7 with `enable`=1.
  - One `mismatch` pulse, `err_code`=01, `err_count`=1, `sticky_err`=1.
  - Following 7→8 produces no error.
- **Missing overflow:** 15→0 with `overflow_in` held 0.
  - `err_code`=10, `err_count` increments, `wrap_count` unchanged.
  - Spurious `overflow_in`=1 while `enable`=0 and count held at 9 also gives `err_code`=10.
- **Enable-low drift:** `enable`=0, count changes 3→4 with overflow pulsing.
  - `err_code`=11, single `mismatch` pulse.
- **Saturation:** with `ERR_CNT_W`=2, inject 5 errors.
  - `err_count`=3 and holds.
  - `sticky_err`=1.
- **Clear/reset collision:** `clear` in the same cycle as an injected mismatch.
  - `mismatch`=0, `err_count`=0, `locked`=0 after that edge; `locked`=1 one edge later.
  - Asserting `rst_n`=0 mid-run zeroes all outputs asynchronously.
